acondicionador_botones: RTL and testbench

- Conditions the raw push-buttons of the date/time editor: synchronizes and debounces them, then generates single-cycle up/down pulses with hold-to-auto-repeat.
- Also keeps the index of the field currently being edited.
- Sits directly upstream of the per-field data counters: pulse_up drives their S input, pulse_down their B input, en_campo drives their en inputs.
- Because pulses are already single-cycle, downstream counters need no edge detection.

---
 rtl/acondicionador_botones.sv | 193 +++++++++++++++++++
 tb/tb_acondicionador_botones.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/acondicionador_botones.sv
// Push-button conditioner for the date/time editor. It synchronizes and debounces four
// buttons, generates single-cycle up/down pulses with hold-to-repeat, and tracks the edited field.
module acondicionador_botones #(
  parameter int unsigned DEB_CYCLES  = 250000,
  parameter int unsigned HOLD_CYCLES = 50000000,
  parameter int unsigned REP_CYCLES  = 10000000,
  parameter int unsigned NUM_FIELDS  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  W_R,
  input  logic                  btn_up,
  input  logic                  btn_down,
  input  logic                  btn_left,
  input  logic                  btn_right,
  output logic                  pulse_up,
  output logic                  pulse_down,
  output logic [2:0]            campo,
  output logic [NUM_FIELDS-1:0] en_campo
);

  localparam int unsigned MaxHr     = (HOLD_CYCLES > REP_CYCLES) ? HOLD_CYCLES : REP_CYCLES;
  localparam int unsigned MaxCycles = (DEB_CYCLES > MaxHr) ? DEB_CYCLES : MaxHr;
  localparam int unsigned CntW      = ($clog2(MaxCycles) < 1) ? 1 : $clog2(MaxCycles);

  localparam logic [CntW-1:0] DebLast   = CntW'(DEB_CYCLES - 1);
  localparam logic [CntW-1:0] HoldLast  = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] RepLast   = CntW'(REP_CYCLES - 1);
  localparam logic [2:0]      LastField = 3'(NUM_FIELDS - 1);

  localparam int unsigned BUp    = 0;
  localparam int unsigned BDown  = 1;
  localparam int unsigned BLeft  = 2;
  localparam int unsigned BRight = 3;

  typedef enum logic [1:0] {StIdle, StHold, StRepeat, StLock} state_e;

  logic [3:0]           sync1_q, sync2_q;
  logic [3:0]           db_d, db_q, db_prev_q;
  logic [3:0][CntW-1:0] deb_cnt_d, deb_cnt_q;
  logic [3:0]           rise;
  logic                 fall_up, fall_down;

  state_e               state_d, state_q;
  logic                 dir_d, dir_q;  // 1 = up, 0 = down
  logic [CntW-1:0]      timer_d, timer_q;
  logic                 w_r_q;
  logic                 emit;
  logic                 act_fall, opp_rise;
  logic                 pulse_up_d, pulse_up_q, pulse_down_d, pulse_down_q;

  logic [2:0]            campo_d, campo_q;
  logic [NUM_FIELDS-1:0] en_campo_d, en_campo_q;

  // Debounce: db follows the synchronized input only after DEB_CYCLES of steady disagreement.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      db_d[i]      = db_q[i];
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (deb_cnt_q[i] == DebLast) begin
          db_d[i]      = sync2_q[i];
          deb_cnt_d[i] = '0;
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  assign rise      = db_q & ~db_prev_q;
  assign fall_up   = ~db_q[BUp] & db_prev_q[BUp];
  assign fall_down = ~db_q[BDown] & db_prev_q[BDown];
  assign act_fall  = dir_q ? fall_up : fall_down;
  assign opp_rise  = dir_q ? rise[BDown] : rise[BUp];

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    timer_d = timer_q;
    emit    = 1'b0;
    if (W_R) begin
      state_d = StIdle;
      timer_d = '0;
    end else if (w_r_q && (db_q[BUp] || db_q[BDown])) begin
      // Button held across the end of an RTC access: wait for a fresh press.
      state_d = StLock;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (db_q[BUp] && db_q[BDown]) begin
            state_d = StLock;
          end else if (rise[BUp]) begin
            emit    = 1'b1;
            dir_d   = 1'b1;
            timer_d = '0;
            state_d = StHold;
          end else if (rise[BDown]) begin
            emit    = 1'b1;
            dir_d   = 1'b0;
            timer_d = '0;
            state_d = StHold;
          end
        end
        StHold: begin
          if (opp_rise) begin
            state_d = StLock;
          end else if (act_fall) begin
            state_d = StIdle;
          end else if (timer_q == HoldLast) begin
            emit    = 1'b1;
            timer_d = '0;
            state_d = StRepeat;
          end else begin
            timer_d = timer_q + CntW'(1);
          end
        end
        StRepeat: begin
          if (opp_rise) begin
            state_d = StLock;
          end else if (act_fall) begin
            state_d = StIdle;
          end else if (timer_q == RepLast) begin
            emit    = 1'b1;
            timer_d = '0;
          end else begin
            timer_d = timer_q + CntW'(1);
          end
        end
        StLock: begin
          if (!db_q[BUp] && !db_q[BDown]) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
    pulse_up_d   = emit & dir_d;
    pulse_down_d = emit & ~dir_d;
  end

  // Field select; simultaneous left and right cancel out.
  always_comb begin
    campo_d = campo_q;
    if (!W_R) begin
      if (rise[BRight] && !rise[BLeft]) begin
        campo_d = (campo_q == LastField) ? 3'd0 : campo_q + 3'd1;
      end else if (rise[BLeft] && !rise[BRight]) begin
        campo_d = (campo_q == 3'd0) ? LastField : campo_q - 3'd1;
      end
    end
    en_campo_d = '0;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      en_campo_d[i] = (campo_d == 3'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      db_q         <= '0;
      db_prev_q    <= '0;
      deb_cnt_q    <= '0;
      state_q      <= StIdle;
      dir_q        <= 1'b0;
      timer_q      <= '0;
      w_r_q        <= 1'b0;
      pulse_up_q   <= 1'b0;
      pulse_down_q <= 1'b0;
      campo_q      <= 3'd0;
      en_campo_q   <= {{(NUM_FIELDS - 1){1'b0}}, 1'b1};
    end else begin
      sync1_q      <= {btn_right, btn_left, btn_down, btn_up};
      sync2_q      <= sync1_q;
      db_q         <= db_d;
      db_prev_q    <= db_q;
      deb_cnt_q    <= deb_cnt_d;
      state_q      <= state_d;
      dir_q        <= dir_d;
      timer_q      <= timer_d;
      w_r_q        <= W_R;
      pulse_up_q   <= pulse_up_d;
      pulse_down_q <= pulse_down_d;
      campo_q      <= campo_d;
      en_campo_q   <= en_campo_d;
    end
  end

  assign pulse_up   = pulse_up_q;
  assign pulse_down = pulse_down_q;
  assign campo      = campo_q;
  assign en_campo   = en_campo_q;

endmodule

// File: tb/tb_acondicionador_botones.sv
// Self-checking bench for acondicionador_botones: directed scenarios plus randomized presses
// compared against pulse timing and field arithmetic computed from the behavioural rules.
module tb_acondicionador_botones;

  localparam int unsigned Deb   = 4;
  localparam int unsigned Hold  = 10;
  localparam int unsigned Rep   = 3;
  localparam int unsigned NF    = 3;
  localparam int unsigned Lat   = Deb + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          w_r = 1'b0;
  logic          btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic          pulse_up, pulse_down;
  logic [2:0]    campo;
  logic [NF-1:0] en_campo;

  int n_cmp = 0;
  int n_err = 0;
  int m_campo = 0;

  acondicionador_botones #(
    .DEB_CYCLES (Deb),
    .HOLD_CYCLES(Hold),
    .REP_CYCLES (Rep),
    .NUM_FIELDS (NF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .W_R       (w_r),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .pulse_up  (pulse_up),
    .pulse_down(pulse_down),
    .campo     (campo),
    .en_campo  (en_campo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Clean press at edge 0 held until edge `hold`: first pulse after Lat edges, a repeat
  // HOLD later, then every REP, and nothing from the edge at which the release takes effect.
  function automatic logic exp_pulse(input int e, input int hold);
    if (e < int'(Lat) || e >= hold + int'(Lat)) return 1'b0;
    if (e == int'(Lat)) return 1'b1;
    if (e < int'(Lat + Hold)) return 1'b0;
    return ((e - int'(Lat + Hold)) % int'(Rep)) == 0;
  endfunction

  task automatic run_press(input bit up, input int hold, input int gap);
    logic exp;
    for (int e = 0; e < hold + gap; e++) begin
      if (up) btn_up = (e < hold);
      else    btn_down = (e < hold);
      tick();
      exp = exp_pulse(e, hold);
      chk("press_pulse_up", 32'(pulse_up), 32'(up ? exp : 1'b0));
      chk("press_pulse_down", 32'(pulse_down), 32'(up ? 1'b0 : exp));
    end
  endtask

  task automatic press_field(input bit l, input bit r);
    btn_left  = l;
    btn_right = r;
    repeat (Deb + 2) tick();
    btn_left  = 1'b0;
    btn_right = 1'b0;
    repeat (Deb + 6) tick();
    if (r && !l) m_campo = (m_campo + 1) % NF;
    if (l && !r) m_campo = (m_campo + NF - 1) % NF;
    chk("field_campo", 32'(campo), 32'(m_campo));
    chk("field_en_campo", 32'(en_campo), 32'(1 << m_campo));
  endtask

  initial begin
    logic exp_dn;
    // Reset state, checked before any clock edge
    #2 rst = 1'b1;
    #2;
    chk("reset_pulse_up", 32'(pulse_up), 32'd0);
    chk("reset_pulse_down", 32'(pulse_down), 32'd0);
    chk("reset_campo", 32'(campo), 32'd0);
    chk("reset_en_campo", 32'(en_campo), 32'd1);
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // Single press, then long hold with auto-repeat
    run_press(1'b1, 8, 12);
    run_press(1'b1, 40, 12);

    // Bouncing input never settles long enough
    for (int e = 0; e < 30; e++) begin
      btn_up = (e < 20) && ((e % 4) < 2);
      tick();
      chk("bounce_pulse_up", 32'(pulse_up), 32'd0);
      chk("bounce_pulse_down", 32'(pulse_down), 32'd0);
    end
    run_press(1'b1, 8, 12);

    // Down held into REPEAT, then up pressed: lock until both released
    for (int e = 0; e < 60; e++) begin
      btn_down = (e < 40);
      btn_up   = (e >= 20 && e < 40);
      tick();
      exp_dn = (e == 6 || e == 16 || e == 19 || e == 22 || e == 25);
      chk("lock_pulse_up", 32'(pulse_up), 32'd0);
      chk("lock_pulse_down", 32'(pulse_down), 32'(exp_dn));
    end
    run_press(1'b1, 8, 12);

    // Field selection: directed then random
    for (int i = 0; i < 4; i++) press_field(1'b0, 1'b1);
    press_field(1'b1, 1'b0);
    press_field(1'b1, 1'b1);
    for (int i = 0; i < 12; i++) begin
      int sel;
      sel = $urandom_range(0, 2);
      press_field(sel != 1, sel != 0);
    end
    if (m_campo == 0) press_field(1'b0, 1'b1);

    // W_R during REPEAT, held button across W_R fall
    for (int e = 0; e < 60; e++) begin
      btn_up = (e < 40);
      w_r    = (e >= 21 && e < 30);
      tick();
      chk("wr_pulse_up", 32'(pulse_up), 32'(e == 6 || e == 16 || e == 19));
      chk("wr_pulse_down", 32'(pulse_down), 32'd0);
      chk("wr_campo_hold", 32'(campo), 32'(m_campo));
    end
    run_press(1'b1, 8, 12);

    // Asynchronous reset while in HOLD with the first pulse high
    btn_up = 1'b1;
    for (int e = 0; e <= int'(Lat); e++) tick();
    chk("pre_rst_pulse_up", 32'(pulse_up), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pulse_up", 32'(pulse_up), 32'd0);
    chk("async_rst_campo", 32'(campo), 32'd0);
    chk("async_rst_en_campo", 32'(en_campo), 32'd1);
    btn_up = 1'b0;
    tick();
    rst = 1'b0;
    m_campo = 0;
    for (int e = 0; e < 20; e++) begin
      tick();
      chk("post_rst_pulse_up", 32'(pulse_up), 32'd0);
    end
    run_press(1'b1, 8, 12);

    // Randomized presses
    for (int i = 0; i < 16; i++) begin
      run_press(1'($urandom_range(0, 1)), int'($urandom_range(5, 50)),
                int'($urandom_range(8, 20)));
    end
    chk("final_campo", 32'(campo), 32'(m_campo));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
